// File: rtl/shift_seq_pkg.sv
// Shared types and HC194 mode encodings for the shift sequencer.
package shift_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // HC194 mode for the captured shift direction (0 = right, 1 = left).
  function automatic logic [1:0] shift_mode(input logic dir);
    return dir ? MODE_SHL : MODE_SHR;
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request and HC194/HC153 control bundle between the sequencer and its user.
interface shift_seq_ctrl_if;
  logic       START;
  logic       DIR;
  logic [3:0] LEN;
  logic [0:3] PAT;
  logic       FILL;
  logic [1:0] S;
  logic [0:3] D;
  logic       DSR;
  logic       DSL;
  logic [1:0] SEL;
  logic [3:0] CNT;
  logic       BUSY;
  logic       DONE;

  modport master (
    output START, DIR, LEN, PAT, FILL,
    input  S, D, DSR, DSL, SEL, CNT, BUSY, DONE
  );

  modport slave (
    input  START, DIR, LEN, PAT, FILL,
    output S, D, DSR, DSL, SEL, CNT, BUSY, DONE
  );
endinterface

// File: rtl/shift_seq_ctrl_step_cnt.sv
// 4-bit step counter: counts completed shifts and flags the final one.
module step_cnt (
  input  logic       CP,
  input  logic       MR,
  input  logic       clr,
  input  logic       en,
  input  logic [3:0] len,
  output logic [3:0] cnt,
  output logic       last
);

  // Clear wins over enable; LEN <= 15 keeps the count from wrapping.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR)
      cnt <= 4'd0;
    else if (clr)
      cnt <= 4'd0;
    else if (en)
      cnt <= cnt + 4'd1;
  end

  // The coming increment brings the count up to LEN; widened so 15 never aliases.
  assign last = (({1'b0, cnt} + 5'd1) == {1'b0, len});

endmodule

// File: rtl/shift_seq_ctrl.sv
// Load-then-shift sequencer driving 74HC194 mode/data/fill and 74HC153 selects.
module shift_seq_ctrl
  import shift_seq_pkg::*;
(
  input  logic            CP,
  input  logic            MR,
  shift_seq_ctrl_if.slave bus
);

  state_t     state;
  logic       dir_q;
  logic       fill_q;
  logic [3:0] len_q;
  logic [1:0] s_q;
  logic [0:3] d_q;
  logic       dsr_q;
  logic       dsl_q;
  logic       busy_q;
  logic       done_q;
  logic [3:0] cnt;
  logic       cnt_last;
  logic       cnt_clr;
  logic       cnt_en;

  assign cnt_clr = (state == IDLE) && bus.START;
  assign cnt_en  = (state == SHIFT);

  step_cnt u_step_cnt (
    .CP   (CP),
    .MR   (MR),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .len  (len_q),
    .cnt  (cnt),
    .last (cnt_last)
  );

  // FSM with capture and registered HC194 controls; outputs change with the state.
  always_ff @(posedge CP or negedge MR) begin
    if (!MR) begin
      state  <= IDLE;
      dir_q  <= 1'b0;
      fill_q <= 1'b0;
      len_q  <= 4'd0;
      s_q    <= MODE_HOLD;
      d_q    <= 4'b0000;
      dsr_q  <= 1'b0;
      dsl_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START) begin
            dir_q  <= bus.DIR;
            fill_q <= bus.FILL;
            len_q  <= bus.LEN;
            d_q    <= bus.PAT;
            s_q    <= MODE_LOAD;
            busy_q <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          if (len_q != 4'd0) begin
            s_q   <= shift_mode(dir_q);
            dsr_q <= dir_q ? 1'b0 : fill_q;
            dsl_q <= dir_q ? fill_q : 1'b0;
            state <= SHIFT;
          end else begin
            s_q    <= MODE_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        SHIFT: begin
          if (cnt_last) begin
            s_q    <= MODE_HOLD;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.S    = s_q;
  assign bus.D    = d_q;
  assign bus.DSR  = dsr_q;
  assign bus.DSL  = dsl_q;
  assign bus.CNT  = cnt;
  assign bus.SEL  = cnt[1:0];
  assign bus.BUSY = busy_q;
  assign bus.DONE = done_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural 74HC194 downstream.
module tb_shift_seq_ctrl;

  logic cp;
  logic mr;
  int   checks;
  int   errors;
  logic [0:3] q_m;

  shift_seq_ctrl_if bus ();

  shift_seq_ctrl dut (
    .CP  (cp),
    .MR  (mr),
    .bus (bus)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Downstream 74HC194: Q[0:3], right shift moves toward Q[3].
  always @(posedge cp or negedge mr) begin
    if (!mr)
      q_m <= 4'b0000;
    else begin
      case (bus.S)
        2'b11:   q_m <= bus.D;
        2'b01:   q_m <= {bus.DSR, q_m[0:2]};
        2'b10:   q_m <= {q_m[1:3], bus.DSL};
        default: q_m <= q_m;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_S"},    32'(bus.S),    32'd0);
    chk({tag, "_D"},    32'(bus.D),    32'd0);
    chk({tag, "_DSR"},  32'(bus.DSR),  32'd0);
    chk({tag, "_DSL"},  32'(bus.DSL),  32'd0);
    chk({tag, "_SEL"},  32'(bus.SEL),  32'd0);
    chk({tag, "_CNT"},  32'(bus.CNT),  32'd0);
    chk({tag, "_BUSY"}, 32'(bus.BUSY), 32'd0);
    chk({tag, "_DONE"}, 32'(bus.DONE), 32'd0);
  endtask

  // One complete run; inputs are scrambled after capture to prove they are latched.
  task automatic run(input string tag, input logic [0:3] pat, input logic dir,
                     input logic fill, input logic [3:0] len, input logic [0:3] exp_q);
    logic [1:0] mode;
    logic [3:0] ci;
    mode = dir ? 2'b10 : 2'b01;
    @(negedge cp);
    bus.PAT = pat; bus.DIR = dir; bus.FILL = fill; bus.LEN = len; bus.START = 1'b1;
    @(negedge cp);
    bus.START = 1'b0;
    chk({tag, "_load_S"},    32'(bus.S),    32'd3);
    chk({tag, "_load_D"},    32'(bus.D),    32'(pat));
    chk({tag, "_load_BUSY"}, 32'(bus.BUSY), 32'd1);
    chk({tag, "_load_CNT"},  32'(bus.CNT),  32'd0);
    bus.PAT = ~pat; bus.DIR = ~dir; bus.FILL = ~fill; bus.LEN = ~len;
    for (int i = 0; i < int'(len); i++) begin
      @(negedge cp);
      ci = 4'(i);
      chk({tag, "_sh_S"},    32'(bus.S),    32'(mode));
      chk({tag, "_sh_BUSY"}, 32'(bus.BUSY), 32'd1);
      chk({tag, "_sh_DONE"}, 32'(bus.DONE), 32'd0);
      chk({tag, "_sh_CNT"},  32'(bus.CNT),  32'(ci));
      chk({tag, "_sh_SEL"},  32'(bus.SEL),  32'(ci[1:0]));
      chk({tag, "_sh_DSR"},  32'(bus.DSR),  32'(dir ? 1'b0 : fill));
      chk({tag, "_sh_DSL"},  32'(bus.DSL),  32'(dir ? fill : 1'b0));
    end
    @(negedge cp);
    chk({tag, "_done_S"},    32'(bus.S),    32'd0);
    chk({tag, "_done_DONE"}, 32'(bus.DONE), 32'd1);
    chk({tag, "_done_BUSY"}, 32'(bus.BUSY), 32'd0);
    chk({tag, "_done_CNT"},  32'(bus.CNT),  32'(len));
    @(negedge cp);
    chk({tag, "_idle_S"},    32'(bus.S),    32'd0);
    chk({tag, "_idle_DONE"}, 32'(bus.DONE), 32'd0);
    chk({tag, "_idle_BUSY"}, 32'(bus.BUSY), 32'd0);
    chk({tag, "_Q"},         32'(q_m),      32'(exp_q));
    bus.START = 1'b0; bus.PAT = 4'b0000; bus.DIR = 1'b0; bus.FILL = 1'b0; bus.LEN = 4'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    mr = 1'b0;
    bus.START = 1'b0; bus.DIR = 1'b0; bus.LEN = 4'd0; bus.PAT = 4'b0000; bus.FILL = 1'b0;
    #3;
    check_reset_outputs("rst");
    repeat (2) @(negedge cp);
    mr = 1'b1;
    @(negedge cp);
    chk("rst_rel_S", 32'(bus.S), 32'd0);

    // Right shift: 1011 -> 0101 -> 0010
    run("shr", 4'b1011, 1'b0, 1'b0, 4'd2, 4'b0010);
    // Left shift with fill 1: 0001 -> 0011 -> 0111 -> 1111
    run("shl", 4'b0001, 1'b1, 1'b1, 4'd3, 4'b1111);
    // Load only
    run("ld0", 4'b0110, 1'b0, 1'b1, 4'd0, 4'b0110);
    // Maximum length, right with fill 1: everything becomes 1
    run("max", 4'b1001, 1'b0, 1'b1, 4'd15, 4'b1111);

    // START handling: pulse mid-run, then hold high through DONE
    @(negedge cp);
    bus.PAT = 4'b1100; bus.DIR = 1'b0; bus.FILL = 1'b1; bus.LEN = 4'd4; bus.START = 1'b1;
    @(negedge cp);
    bus.START = 1'b0;
    chk("st_load_S", 32'(bus.S), 32'd3);
    @(negedge cp);
    chk("st_sh0_S", 32'(bus.S), 32'd1);
    bus.START = 1'b1;
    @(negedge cp);
    chk("st_sh1_S",   32'(bus.S),    32'd1);
    chk("st_sh1_CNT", 32'(bus.CNT),  32'd1);
    chk("st_sh1_BUSY",32'(bus.BUSY), 32'd1);
    bus.START = 1'b0;
    @(negedge cp);
    chk("st_sh2_CNT", 32'(bus.CNT), 32'd2);
    @(negedge cp);
    chk("st_sh3_CNT", 32'(bus.CNT), 32'd3);
    bus.START = 1'b1; bus.PAT = 4'b0101; bus.DIR = 1'b1; bus.FILL = 1'b0; bus.LEN = 4'd1;
    @(negedge cp);
    chk("st_done_DONE", 32'(bus.DONE), 32'd1);
    chk("st_done_CNT",  32'(bus.CNT),  32'd4);
    chk("st_done_S",    32'(bus.S),    32'd0);
    @(negedge cp);
    chk("st_idle_S",    32'(bus.S),    32'd0);
    chk("st_idle_BUSY", 32'(bus.BUSY), 32'd0);
    chk("st_idle_DONE", 32'(bus.DONE), 32'd0);
    chk("st_A_Q",       32'(q_m),      32'hF);
    @(negedge cp);
    bus.START = 1'b0;
    chk("st_B_load_S",    32'(bus.S),    32'd3);
    chk("st_B_load_D",    32'(bus.D),    32'h5);
    chk("st_B_load_BUSY", 32'(bus.BUSY), 32'd1);
    chk("st_B_load_CNT",  32'(bus.CNT),  32'd0);
    @(negedge cp);
    chk("st_B_sh_S",   32'(bus.S),   32'd2);
    chk("st_B_sh_DSL", 32'(bus.DSL), 32'd0);
    chk("st_B_sh_DSR", 32'(bus.DSR), 32'd0);
    @(negedge cp);
    chk("st_B_done_DONE", 32'(bus.DONE), 32'd1);
    chk("st_B_done_CNT",  32'(bus.CNT),  32'd1);
    @(negedge cp);
    chk("st_B_idle_S", 32'(bus.S), 32'd0);
    chk("st_B_Q",      32'(q_m),   32'hA);
    @(negedge cp);
    chk("st_norun_S",    32'(bus.S),    32'd0);
    chk("st_norun_BUSY", 32'(bus.BUSY), 32'd0);

    // Asynchronous abort mid-SHIFT
    @(negedge cp);
    bus.PAT = 4'b1111; bus.DIR = 1'b0; bus.FILL = 1'b1; bus.LEN = 4'd9; bus.START = 1'b1;
    @(negedge cp);
    bus.START = 1'b0;
    repeat (4) @(negedge cp);
    chk("ab_pre_CNT",  32'(bus.CNT),  32'd3);
    chk("ab_pre_BUSY", 32'(bus.BUSY), 32'd1);
    #2;
    mr = 1'b0;
    #1;
    check_reset_outputs("ab");
    chk("ab_Q", 32'(q_m), 32'd0);
    @(negedge cp);
    chk("ab_low_DONE", 32'(bus.DONE), 32'd0);
    mr = 1'b1;
    repeat (2) begin
      @(negedge cp);
      chk("ab_rel_S",    32'(bus.S),    32'd0);
      chk("ab_rel_BUSY", 32'(bus.BUSY), 32'd0);
      chk("ab_rel_DONE", 32'(bus.DONE), 32'd0);
      chk("ab_rel_CNT",  32'(bus.CNT),  32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
